plic_target_arbiter: RTL and testbench
======================================

# plic_target_arbiter

Per-target claim/complete controller for the PLIC. Arbitrates among all gateway interrupt-pending bits enabled for one target and selects the highest-priority source above the target threshold. Presents the winning ID and the target interrupt line, and converts register-bus claim reads and complete writes into one-cycle claim/complete strobes towards the individual gateways. One instance per target sits between the gateway array and the register interface.

## Interface
- SOURCES, 16: number of interrupt sources, IDs 1..SOURCES; ID 0 means "no interrupt".
- PRIORITIES, 7: highest priority level; level 0 means "never interrupt".
- ID_BITS, $clog2(SOURCES+1): derived, width of IDs.
- PRIO_BITS, $clog2(PRIORITIES+1): derived, width of priority and threshold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ip  in  SOURCES  gateway pending bits; bit i-1 belongs to source ID i.
- ie  in  SOURCES  target enable bits, same indexing.
- prio  in  SOURCES*PRIO_BITS  source priorities, packed; source i at bits [i*PRIO_BITS-1 -: PRIO_BITS].
- threshold  in  PRIO_BITS  target priority threshold.
- irq  out  1  target interrupt request.
- claim_id  out  ID_BITS  current winning ID, 0 if none.
- claim_rd  in  1  single-cycle strobe: bus reads the claim register this cycle.
- complete_wr  in  1  single-cycle strobe: bus writes the complete register.
- complete_id  in  ID_BITS  ID written with complete_wr.
- gw_claim  out  SOURCES  one-hot claim strobes to gateways.
- gw_complete  out  SOURCES  one-hot complete strobes to gateways.

## Operation
- Eligible source i: ip[i-1] & ie[i-1] & !claimed[i] & prio(i) != 0.
- Winner: eligible source with highest priority; ties go to the lowest ID.
- irq = 1 iff a winner exists and its priority > threshold (strict). claim_id = winner ID when irq = 1, else 0.
- `claimed` is a SOURCES-bit bitmap of IDs claimed by this target and not yet completed. It is cleared by reset.
- Claim: claim_rd at cycle t with claim_id = k != 0 has the following effects:
  - the bus samples k at t;
  - gw_claim[k-1] = 1 at t+1 only;
  - claimed[k] is set at t+1.
- claim_rd with claim_id = 0 does nothing. The bus reads 0.
- Complete: complete_wr at t with complete_id = k:
  - If 1 <= k <= SOURCES and claimed[k] = 1: gw_complete[k-1] = 1 at t+1 only, and claimed[k] is cleared at t+1.
  - Otherwise the write is ignored, with no strobe.
- Simultaneous claim_rd and complete_wr in one cycle: both are processed. complete checks `claimed` as it stood before this cycle's claim. A claim can never return an ID already in `claimed`.
- Back-to-back claim_rd strobes are legal. Blanking (see Timing) makes them return 0 until re-arbitration completes.
- Reset values: irq = 0, claim_id = 0, gw_claim = 0, gw_complete = 0, `claimed` = 0, and all pipeline registers 0.
- rst asserted mid-operation clears everything on the next edge. Pending strobes are dropped.

## Timing
- Arbitration pipeline is 2 cycles: a change on ip, ie, prio, threshold or `claimed` at the cycle-t edge is reflected on irq and claim_id from t+2.
- The internal split of the pipeline is free, but the latency is exactly 2.
- Claim blanking: after a claim at t (k != 0), irq = 0 and claim_id = 0 at t+1 and t+2. From t+3 the outputs reflect arbitration that excludes k.
- Complete does not blank. A completed source re-enters arbitration and is visible on the outputs 2 cycles after claimed[k] clears, subject to its gateway ip.
- gw_claim and gw_complete are registered. Each is at most one-hot, and each is high for exactly 1 cycle per accepted request.
- No combinational path from claim_rd or complete_wr to any output.

## Test plan
- Reset: hold rst 2 cycles with ip all 1 -> irq = 0, claim_id = 0, no strobes. Release; 2 cycles later claim_id is the highest-priority ID.
- Priority and tie:
  - Sources 3 and 5 at prio 4, source 9 at prio 2, threshold 1 -> claim_id = 3, irq = 1.
  - Raise threshold to 4 -> irq = 0 and claim_id = 0 two cycles later.
- Claim flow: claim_rd with claim_id = 3 -> gw_claim = 0x0004 for 1 cycle; irq = 0 for 2 cycles; then claim_id = 5 while ip[2] remains 1.
- Complete:
  - complete_wr ID 3 after the claim -> gw_complete = 0x0004 once; ID 3 is eligible again.
  - complete_wr ID 7 (never claimed), ID 0, or ID 17 -> no strobe.
- Simultaneous: claim_rd (claim_id = 5) and complete_wr ID 3 in the same cycle -> gw_claim[4] and gw_complete[2] both pulse at t+1; `claimed` = {5}.
- Reset mid-claim: rst in the cycle after claim_rd -> gw_claim = 0 and `claimed` = 0; the source is re-arbitrated after release.

Source files
------------

// File: rtl/plic_target_arbiter.sv
// rtl/plic_target_arbiter.sv - per-target PLIC arbiter with claim/complete strobes
module plic_target_arbiter #(
  parameter int SOURCES    = 16,
  parameter int PRIORITIES = 7,
  parameter int ID_BITS    = $clog2(SOURCES + 1),
  parameter int PRIO_BITS  = $clog2(PRIORITIES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SOURCES-1:0]             ip,
  input  logic [SOURCES-1:0]             ie,
  input  logic [SOURCES*PRIO_BITS-1:0]   prio,
  input  logic [PRIO_BITS-1:0]           threshold,
  output logic                           irq,
  output logic [ID_BITS-1:0]             claim_id,
  input  logic                           claim_rd,
  input  logic                           complete_wr,
  input  logic [ID_BITS-1:0]             complete_id,
  output logic [SOURCES-1:0]             gw_claim,
  output logic [SOURCES-1:0]             gw_complete
);

  logic [SOURCES*PRIO_BITS-1:0] elig_prio_q, elig_prio_d;
  logic [PRIO_BITS-1:0]         thr_q, thr_d;
  logic                         irq_q, irq_d;
  logic [ID_BITS-1:0]           id_q, id_d;
  logic [SOURCES-1:0]           claimed_q, claimed_d;
  logic [SOURCES-1:0]           gw_claim_q, gw_claim_d;
  logic [SOURCES-1:0]           gw_complete_q, gw_complete_d;

  logic [PRIO_BITS-1:0]         best_prio;
  logic [ID_BITS-1:0]           best_id;
  logic                         claim_fire;
  logic                         blank;

  // Stage 1: mask each source's priority to 0 unless it is eligible.
  always_comb begin
    elig_prio_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (ip[i] && ie[i] && !claimed_q[i]) begin
        elig_prio_d[i*PRIO_BITS +: PRIO_BITS] = prio[i*PRIO_BITS +: PRIO_BITS];
      end
    end
    thr_d = threshold;
  end

  // Stage 2: ascending scan with strict '>' keeps the lowest ID on ties.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (elig_prio_q[i*PRIO_BITS +: PRIO_BITS] > best_prio) begin
        best_prio = elig_prio_q[i*PRIO_BITS +: PRIO_BITS];
        best_id   = ID_BITS'(i + 1);
      end
    end
    claim_fire = claim_rd && (id_q != '0);
    // Stage 1 still holds pre-claim state for two edges after a claim.
    blank      = claim_fire || (gw_claim_q != '0);
    irq_d      = !blank && (best_prio > thr_q);
    id_d       = irq_d ? best_id : '0;
  end

  always_comb begin
    gw_claim_d    = '0;
    gw_complete_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (claim_fire && (id_q == ID_BITS'(i + 1))) begin
        gw_claim_d[i] = 1'b1;
      end
      if (complete_wr && (complete_id == ID_BITS'(i + 1)) && claimed_q[i]) begin
        gw_complete_d[i] = 1'b1;
      end
    end
    claimed_d = (claimed_q | gw_claim_d) & ~gw_complete_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elig_prio_q   <= '0;
      thr_q         <= '0;
      irq_q         <= 1'b0;
      id_q          <= '0;
      claimed_q     <= '0;
      gw_claim_q    <= '0;
      gw_complete_q <= '0;
    end else begin
      elig_prio_q   <= elig_prio_d;
      thr_q         <= thr_d;
      irq_q         <= irq_d;
      id_q          <= id_d;
      claimed_q     <= claimed_d;
      gw_claim_q    <= gw_claim_d;
      gw_complete_q <= gw_complete_d;
    end
  end

  assign irq         = irq_q;
  assign claim_id    = id_q;
  assign gw_claim    = gw_claim_q;
  assign gw_complete = gw_complete_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// tb/tb_plic_target_arbiter.sv - directed bench for plic_target_arbiter
module tb_plic_target_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ip, ie;
  logic [47:0] prio;
  logic [2:0]  threshold;
  logic        irq;
  logic [4:0]  claim_id;
  logic        claim_rd, complete_wr;
  logic [4:0]  complete_id;
  logic [15:0] gw_claim, gw_complete;

  int total = 0;
  int bad   = 0;

  plic_target_arbiter dut (
    .clk(clk), .rst(rst), .ip(ip), .ie(ie), .prio(prio), .threshold(threshold),
    .irq(irq), .claim_id(claim_id), .claim_rd(claim_rd), .complete_wr(complete_wr),
    .complete_id(complete_id), .gw_claim(gw_claim), .gw_complete(gw_complete)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_irq, input logic [4:0] exp_id);
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    check({tag, "_id"}, {27'd0, claim_id}, {27'd0, exp_id});
  endtask

  task automatic do_complete(input logic [4:0] id);
    complete_wr = 1'b1;
    complete_id = id;
    tick();
    complete_wr = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    rst = 1'b1;
    ip = 16'hFFFF;
    ie = 16'hFFFF;
    prio = '0;
    prio[2*3 +: 3] = 3'd4;
    prio[4*3 +: 3] = 3'd4;
    prio[8*3 +: 3] = 3'd2;
    threshold = 3'd1;
    claim_rd = 1'b0;
    complete_wr = 1'b0;
    complete_id = '0;

    tick();
    tick();
    check_out("reset", 1'b0, 5'd0);
    check("reset_gw_claim", {16'd0, gw_claim}, 32'd0);
    check("reset_gw_complete", {16'd0, gw_complete}, 32'd0);

    rst = 1'b0;
    tick();
    check_out("release_lat1", 1'b0, 5'd0);
    tick();
    check_out("release_lat2", 1'b1, 5'd3);

    ip = 16'h0114;
    tick(); tick();
    check_out("tie_lowest", 1'b1, 5'd3);

    threshold = 3'd4;
    tick();
    check_out("thr_lat1", 1'b1, 5'd3);
    tick();
    check_out("thr_strict", 1'b0, 5'd0);

    // Nothing above threshold: a claim read returns 0 and does nothing.
    claim_rd = 1'b1;
    tick();
    claim_rd = 1'b0;
    check("claim_zero_strobe", {16'd0, gw_claim}, 32'd0);
    threshold = 3'd1;
    tick(); tick();
    check_out("thr_restore", 1'b1, 5'd3);

    ie = 16'hFFFB;
    tick(); tick();
    check_out("ie_mask", 1'b1, 5'd5);
    ie = 16'hFFFF;
    tick(); tick();
    check_out("ie_restore", 1'b1, 5'd3);

    claim_rd = 1'b1;
    tick();
    claim_rd = 1'b0;
    check("claim3_strobe", {16'd0, gw_claim}, 32'h0004);
    check_out("claim3_blank1", 1'b0, 5'd0);
    tick();
    check("claim3_strobe_off", {16'd0, gw_claim}, 32'd0);
    check_out("claim3_blank2", 1'b0, 5'd0);
    tick();
    check_out("claim3_next", 1'b1, 5'd5);

    do_complete(5'd7);
    check("cmp7_none", {16'd0, gw_complete}, 32'd0);
    do_complete(5'd0);
    check("cmp0_none", {16'd0, gw_complete}, 32'd0);
    do_complete(5'd17);
    check("cmp17_none", {16'd0, gw_complete}, 32'd0);
    check_out("cmp_ignored", 1'b1, 5'd5);

    claim_rd = 1'b1;
    complete_wr = 1'b1;
    complete_id = 5'd3;
    tick();
    claim_rd = 1'b0;
    complete_wr = 1'b0;
    complete_id = '0;
    check("sim_claim", {16'd0, gw_claim}, 32'h0010);
    check("sim_complete", {16'd0, gw_complete}, 32'h0004);
    tick();
    check("sim_claim_off", {16'd0, gw_claim}, 32'd0);
    check("sim_complete_off", {16'd0, gw_complete}, 32'd0);
    check_out("sim_blank2", 1'b0, 5'd0);
    tick();
    check_out("sim_reenter3", 1'b1, 5'd3);

    claim_rd = 1'b1;
    tick();
    claim_rd = 1'b0;
    check("claim3b_strobe", {16'd0, gw_claim}, 32'h0004);
    tick(); tick();
    check_out("only9_left", 1'b1, 5'd9);

    do_complete(5'd5);
    check("cmp5_strobe", {16'd0, gw_complete}, 32'h0010);
    check_out("cmp5_noblank", 1'b1, 5'd9);
    tick();
    check("cmp5_strobe_off", {16'd0, gw_complete}, 32'd0);
    check_out("cmp5_lat1", 1'b1, 5'd9);
    tick();
    check_out("cmp5_reenter", 1'b1, 5'd5);

    do_complete(5'd5);
    check("cmp5_dup", {16'd0, gw_complete}, 32'd0);
    do_complete(5'd3);
    check("cmp3_strobe", {16'd0, gw_complete}, 32'h0004);
    do_complete(5'd3);
    check("cmp3_dup", {16'd0, gw_complete}, 32'd0);
    tick();
    check_out("cmp3_reenter", 1'b1, 5'd3);

    // Reset in the cycle after a claim: claimed bitmap must be wiped.
    claim_rd = 1'b1;
    tick();
    claim_rd = 1'b0;
    check("rclaim_strobe", {16'd0, gw_claim}, 32'h0004);
    rst = 1'b1;
    tick();
    check("rclaim_gw", {16'd0, gw_claim}, 32'd0);
    check_out("rclaim_out", 1'b0, 5'd0);
    rst = 1'b0;
    tick(); tick();
    check_out("rclaim_rearb", 1'b1, 5'd3);

    // Reset coincident with a claim drops the strobe.
    claim_rd = 1'b1;
    rst = 1'b1;
    tick();
    claim_rd = 1'b0;
    rst = 1'b0;
    check("rst_drop_strobe", {16'd0, gw_claim}, 32'd0);
    tick(); tick();
    check_out("rst_drop_rearb", 1'b1, 5'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
